// File: rtl/data_mem_responder.sv
// Data-bus target: word RAM plus GPIO/timer register bank behind an MMIO tag.
// Latency: reads registered, data valid 1 cycle after the sampling edge; writes commit on the sampling edge.
// Backpressure: none; one access per cycle is always accepted, no wait states.
module data_mem_responder #(
    parameter int          ADDR_W   = 10,
    parameter int          GPIO_W   = 8,
    parameter logic [15:0] MMIO_TAG = 16'hFFFF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CS,
    input  logic              WR_RD,
    input  logic [31:0]       ADDR,
    input  logic [31:0]       Data_BUS_WRITE,
    output logic [31:0]       Data_BUS_READ,
    input  logic [GPIO_W-1:0] GPIO_IN,
    output logic [GPIO_W-1:0] GPIO_OUT,
    output logic              TIMER_IRQ
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [7:0] OFF_GPIO_OUT = 8'h00;
    localparam logic [7:0] OFF_GPIO_IN  = 8'h04;
    localparam logic [7:0] OFF_COUNT    = 8'h08;
    localparam logic [7:0] OFF_CTRL     = 8'h0C;
    localparam logic [7:0] OFF_CMP      = 8'h10;

    logic [31:0]       mem [DEPTH];

    logic [GPIO_W-1:0] gpio_sync1;
    logic [GPIO_W-1:0] gpio_sync2;
    logic [31:0]       count;
    logic [31:0]       cmp;
    logic              en;
    logic              irq_en;
    logic              flag;

    logic              is_mmio;
    logic [7:0]        off;
    logic [ADDR_W-1:0] ram_idx;
    logic              wr_acc;
    logic              rd_acc;
    logic              ram_wr;
    logic              reg_wr;
    logic              flag_set;
    logic [31:0]       reg_rdata;
    logic              unused_addr;

    // Higher RAM address bits alias and the byte lane bits are ignored.
    assign unused_addr = ^ADDR;

    assign is_mmio  = (ADDR[31:16] == MMIO_TAG);
    assign off      = ADDR[7:0];
    assign ram_idx  = ADDR[ADDR_W+1:2];
    assign wr_acc   = CS & WR_RD;
    assign rd_acc   = CS & ~WR_RD;
    assign ram_wr   = wr_acc & ~is_mmio & ~RST;
    assign reg_wr   = wr_acc & is_mmio;
    // Match is judged on the pre-increment count with the enable already in force.
    assign flag_set = en & (count == cmp);

    assign TIMER_IRQ = flag & irq_en;

    // Register-bank read mux; unmapped offsets and unused bits return zero.
    always_comb begin
        reg_rdata = '0;
        case (off)
            OFF_GPIO_OUT: reg_rdata[GPIO_W-1:0] = GPIO_OUT;
            OFF_GPIO_IN:  reg_rdata[GPIO_W-1:0] = gpio_sync2;
            OFF_COUNT:    reg_rdata = count;
            OFF_CTRL:     reg_rdata[2:0] = {flag, irq_en, en};
            OFF_CMP:      reg_rdata = cmp;
            default:      reg_rdata = '0;
        endcase
    end

    // RAM write port; contents are deliberately not reset, and reset blocks a write.
    always_ff @(posedge CLK) begin
        if (ram_wr) begin
            mem[ram_idx] <= Data_BUS_WRITE;
        end
    end

    // Read data register, GPIO synchronizer, timer and register-bank updates.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Data_BUS_READ <= '0;
            GPIO_OUT      <= '0;
            gpio_sync1    <= '0;
            gpio_sync2    <= '0;
            count         <= '0;
            cmp           <= '0;
            en            <= 1'b0;
            irq_en        <= 1'b0;
            flag          <= 1'b0;
        end else begin
            gpio_sync1 <= GPIO_IN;
            gpio_sync2 <= gpio_sync1;

            if (rd_acc) begin
                Data_BUS_READ <= is_mmio ? reg_rdata : mem[ram_idx];
            end

            // A CPU write to COUNT takes priority over the running increment.
            if (reg_wr && off == OFF_COUNT) begin
                count <= Data_BUS_WRITE;
            end else if (en) begin
                count <= count + 32'd1;
            end

            if (reg_wr && off == OFF_GPIO_OUT) begin
                GPIO_OUT <= Data_BUS_WRITE[GPIO_W-1:0];
            end

            if (reg_wr && off == OFF_CMP) begin
                cmp <= Data_BUS_WRITE;
            end

            if (reg_wr && off == OFF_CTRL) begin
                en     <= Data_BUS_WRITE[0];
                irq_en <= Data_BUS_WRITE[1];
            end

            // Set beats write-1-to-clear when both land on the same edge.
            if (flag_set) begin
                flag <= 1'b1;
            end else if (reg_wr && off == OFF_CTRL && Data_BUS_WRITE[2]) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table of bus ops plus timer/GPIO/reset sequences.
// Read expectations are queued at drive time and popped when the data appears.
// Non-read cycles check that the read bus holds its last value.
module tb_data_mem_responder;

    localparam logic [31:0] MM = 32'hFFFF_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CS = 1'b0;
    logic        WR_RD = 1'b0;
    logic [31:0] ADDR = '0;
    logic [31:0] Data_BUS_WRITE = '0;
    logic [31:0] Data_BUS_READ;
    logic [7:0]  GPIO_IN = '0;
    logic [7:0]  GPIO_OUT;
    logic        TIMER_IRQ;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = '0;

    typedef enum logic [1:0] {OP_IDLE, OP_RD, OP_WR} op_e;
    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] dat;
    } vec_t;

    data_mem_responder dut (
        .CLK(CLK), .RST(RST), .CS(CS), .WR_RD(WR_RD), .ADDR(ADDR),
        .Data_BUS_WRITE(Data_BUS_WRITE), .Data_BUS_READ(Data_BUS_READ),
        .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT), .TIMER_IRQ(TIMER_IRQ)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle. For reads dat is the expected read value.
    task automatic bus_op(input op_e op, input logic [31:0] addr, input logic [31:0] dat);
        logic [31:0] e;
        @(negedge CLK);
        case (op)
            OP_RD: begin
                CS = 1'b1; WR_RD = 1'b0; ADDR = addr; Data_BUS_WRITE = 32'h0BAD_F00D;
                exp_q.push_back(dat);
            end
            OP_WR: begin
                CS = 1'b1; WR_RD = 1'b1; ADDR = addr; Data_BUS_WRITE = dat;
            end
            default: begin
                // Idle with write-looking qualifiers: CS low must have no effect.
                CS = 1'b0; WR_RD = 1'b1; ADDR = 32'h10; Data_BUS_WRITE = 32'h0BAD_F00D;
            end
        endcase
        @(posedge CLK);
        #1;
        CS = 1'b0;
        if (op == OP_RD) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("read@%h", addr), Data_BUS_READ, e);
                last_rd = e;
            end
        end else begin
            check($sformatf("hold_after_%s@%h", op.name(), addr), Data_BUS_READ, last_rd);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_op(OP_IDLE, 32'h0, 32'h0);
    endtask

    vec_t tbl[$];

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("reset_rdata", Data_BUS_READ, 32'h0);
        check("reset_gpio_out", {24'h0, GPIO_OUT}, 32'h0);
        check("reset_irq", {31'h0, TIMER_IRQ}, 32'h0);

        // RAM, aliasing, read hold, GPIO, unmapped and RO registers.
        tbl = '{
            '{OP_WR, 32'h0000_0010, 32'hDEAD_BEEF},
            '{OP_RD, 32'h0000_0010, 32'hDEAD_BEEF},
            '{OP_RD, 32'h0000_1010, 32'hDEAD_BEEF},
            '{OP_IDLE, 32'h0, 32'h0}, '{OP_IDLE, 32'h0, 32'h0}, '{OP_IDLE, 32'h0, 32'h0},
            '{OP_IDLE, 32'h0, 32'h0}, '{OP_IDLE, 32'h0, 32'h0},
            '{OP_WR, 32'h0000_0014, 32'h0000_1234},
            '{OP_RD, 32'h0000_0014, 32'h0000_1234},
            '{OP_RD, 32'h0000_0013, 32'hDEAD_BEEF},
            '{OP_WR, 32'h0000_0800, 32'h0000_AAAA},
            '{OP_RD, 32'h0000_0800, 32'h0000_AAAA},
            '{OP_RD, 32'h0000_0010, 32'hDEAD_BEEF},
            '{OP_WR, MM | 32'h00, 32'hFFFF_FFA5},
            '{OP_RD, MM | 32'h00, 32'h0000_00A5},
            '{OP_WR, MM | 32'h04, 32'hFFFF_FFFF},
            '{OP_RD, MM | 32'h04, 32'h0000_0000},
            '{OP_WR, MM | 32'h10, 32'h1234_5678},
            '{OP_RD, MM | 32'h10, 32'h1234_5678},
            '{OP_WR, MM | 32'h20, 32'hDEAD_BEEF},
            '{OP_RD, MM | 32'h20, 32'h0000_0000},
            '{OP_RD, MM | 32'h0C, 32'h0000_0000}
        };
        foreach (tbl[i]) bus_op(tbl[i].op, tbl[i].addr, tbl[i].dat);
        check("gpio_out_pin", {24'h0, GPIO_OUT}, 32'h0000_00A5);

        // GPIO input synchronizer latency.
        GPIO_IN = 8'h3C;
        bus_op(OP_RD, MM | 32'h04, 32'h0);
        bus_op(OP_RD, MM | 32'h04, 32'h0);
        bus_op(OP_RD, MM | 32'h04, 32'h3C);
        GPIO_IN = 8'h00;

        // Timer match, IRQ, W1C.
        bus_op(OP_WR, MM | 32'h10, 32'd5);
        bus_op(OP_WR, MM | 32'h08, 32'd0);
        bus_op(OP_WR, MM | 32'h0C, 32'h3);
        idle(5);
        check("irq_before_match", {31'h0, TIMER_IRQ}, 32'h0);
        idle(1);
        check("irq_after_match", {31'h0, TIMER_IRQ}, 32'h1);
        bus_op(OP_RD, MM | 32'h08, 32'd6);
        bus_op(OP_RD, MM | 32'h0C, 32'h7);
        bus_op(OP_WR, MM | 32'h0C, 32'h7);
        bus_op(OP_RD, MM | 32'h0C, 32'h3);
        check("irq_after_clear", {31'h0, TIMER_IRQ}, 32'h0);

        // W1C on the exact match edge: set wins.
        bus_op(OP_WR, MM | 32'h08, 32'd0);
        idle(5);
        bus_op(OP_WR, MM | 32'h0C, 32'h4);
        bus_op(OP_RD, MM | 32'h0C, 32'h4);
        check("irq_en_off", {31'h0, TIMER_IRQ}, 32'h0);
        bus_op(OP_WR, MM | 32'h0C, 32'h4);
        bus_op(OP_RD, MM | 32'h0C, 32'h0);

        // Count wrap and write override.
        bus_op(OP_WR, MM | 32'h0C, 32'h1);
        bus_op(OP_WR, MM | 32'h08, 32'hFFFF_FFFE);
        idle(1);
        bus_op(OP_RD, MM | 32'h08, 32'hFFFF_FFFF);
        bus_op(OP_RD, MM | 32'h08, 32'h0000_0000);
        bus_op(OP_WR, MM | 32'h08, 32'h0000_0100);
        bus_op(OP_RD, MM | 32'h08, 32'h0000_0100);
        bus_op(OP_WR, MM | 32'h0C, 32'h0);

        // Reset in the middle of a GPIO write with the IRQ raised.
        bus_op(OP_WR, 32'h0000_0040, 32'hCAFE_0001);
        bus_op(OP_WR, MM | 32'h10, 32'd0);
        bus_op(OP_WR, MM | 32'h08, 32'd0);
        bus_op(OP_WR, MM | 32'h0C, 32'h3);
        idle(1);
        check("irq_before_reset", {31'h0, TIMER_IRQ}, 32'h1);
        bus_op(OP_RD, 32'h0000_0040, 32'hCAFE_0001);
        @(negedge CLK);
        RST = 1'b1; CS = 1'b1; WR_RD = 1'b1; ADDR = MM; Data_BUS_WRITE = 32'h77;
        @(posedge CLK);
        #1;
        RST = 1'b0; CS = 1'b0;
        last_rd = '0;
        check("rst_gpio_out", {24'h0, GPIO_OUT}, 32'h0);
        check("rst_rdata", Data_BUS_READ, 32'h0);
        check("rst_irq", {31'h0, TIMER_IRQ}, 32'h0);
        bus_op(OP_RD, MM | 32'h00, 32'h0);
        bus_op(OP_RD, MM | 32'h04, 32'h0);
        bus_op(OP_RD, MM | 32'h08, 32'h0);
        bus_op(OP_RD, MM | 32'h0C, 32'h0);
        bus_op(OP_RD, MM | 32'h10, 32'h0);
        bus_op(OP_RD, 32'h0000_0040, 32'hCAFE_0001);
        check("gpio_out_after_reset", {24'h0, GPIO_OUT}, 32'h0);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Target-side endpoint of the CPU data bus: decodes `CS`/`WR_RD`/`ADDR`, serves word reads and writes from an on-chip RAM, and exposes a memory-mapped GPIO and timer register bank.
- Sits beside `cpu` at the top level: its `Data_BUS_READ` drives the CPU read bus and `TIMER_IRQ` is exported for interrupt use.
- Single clock domain, no wait states. Reads are registered with a fixed 1-cycle latency; writes commit on the sampling edge.

## Interface

Parameters:

- `ADDR_W`, default 10: RAM word-address bits (1024 words × 32 b).
- `GPIO_W`, default 8: GPIO input/output width.
- `MMIO_TAG`, default 16'hFFFF: value of `ADDR[31:16]` that selects the register bank.

Ports:

- `CLK`  in  1: system clock; all state updates on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `CS`  in  1: bus access strobe, one access per cycle while high.
- `WR_RD`  in  1: 1 = write, 0 = read; qualified by `CS`.
- `ADDR`  in  32: byte address. `ADDR[1:0]` is ignored (word accesses only).
- `Data_BUS_WRITE`  in  32: write data.
- `Data_BUS_READ`  out  32: registered read data.
- `GPIO_IN`  in  GPIO_W: asynchronous external inputs.
- `GPIO_OUT`  out  GPIO_W: output register.
- `TIMER_IRQ`  out  1: level interrupt, equal to `FLAG & IRQ_EN`.

## Operation

Address decode:

- MMIO space when `ADDR[31:16] == MMIO_TAG`; RAM space otherwise.
- RAM index is `ADDR[ADDR_W+1:2]`. Higher address bits alias (the space wraps modulo the RAM size).

MMIO registers (offset `ADDR[7:0]`):

- 0x00 `GPIO_OUT`: RW, low `GPIO_W` bits; upper bits read as 0.
- 0x04 `GPIO_IN`: RO, value after a 2-flop synchronizer; writes ignored.
- 0x08 `COUNT`: RW, 32-bit. Increments by 1 each cycle while `EN`=1; wraps from 0xFFFFFFFF to 0.
- 0x0C `CTRL`: bit0 `EN` (RW), bit1 `IRQ_EN` (RW), bit2 `FLAG` (RO, write-1-to-clear). Other bits read 0.
- 0x10 `CMP`: RW, 32-bit.
- Any other offset reads 0; writes to it are ignored.

Timer:

- `FLAG` sets on any cycle where `EN`=1 and the pre-increment `COUNT == CMP`.
- A CPU write to `COUNT` overrides the increment in that cycle.
- If a set condition and a W1C hit `FLAG` in the same cycle, set wins.

Read path:

- On `CS=1`, `WR_RD=0`: the selected RAM word or register is captured into `Data_BUS_READ`.
- Otherwise `Data_BUS_READ` holds its previous value.

Write path:

- On `CS=1`, `WR_RD=1`: the target is updated at that edge.
- A write does not change `Data_BUS_READ`.
- `CS=0` produces no side effects.

Reset:

- Sets `Data_BUS_READ`, `GPIO_OUT`, `COUNT`, `CTRL`, `CMP`, the synchronizer flops and `TIMER_IRQ` to 0.
- RAM contents are not reset (undefined until written).
- Reset asserted mid-access: the reset wins; the access is dropped and no write commits.

## Timing

- Read latency: 1 cycle. Request sampled at edge N; data valid after edge N and held until the next read.
- Back-to-back reads, one per cycle, are supported at full rate.
- Write then read of the same address in the next cycle returns the new data (no bypass needed, since the write commits first).
- Read and write to the same address cannot coincide: the bus issues one access per cycle.
- `GPIO_IN` latency: a pin change is visible to a read sampled 2 edges after the change is registered.
- `TIMER_IRQ` rises the cycle after the match edge, i.e. combinationally from the registered `FLAG`/`IRQ_EN`.
- `COUNT` read returns the value before that edge's increment.
- Throughput: one access per `CLK` cycle with no stalls. The block must close timing at the `CLK_SYS` rate used by `cpu`.

## Test plan

- RAM: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 next cycle → `Data_BUS_READ` = 0xDEADBEEF one cycle after the read. A read of 0x0000_1010 (alias at `ADDR_W`=10) also returns 0xDEADBEEF.
- Read hold: read 0x10, then hold `CS`=0 for 5 cycles, then write 0x1234 to 0x14 → `Data_BUS_READ` stays 0xDEADBEEF throughout.
- GPIO: write 0xFFFFFFA5 to 0xFFFF0000 → `GPIO_OUT`=0xA5 and a read-back returns 0x000000A5. Drive `GPIO_IN`=0x3C → a read of 0xFFFF0004 returns 0x3C only when sampled ≥2 edges after the change.
- Timer: write `CMP`=5, `COUNT`=0, `CTRL`=0x3 → `FLAG` sets when `COUNT` passes 5 and `TIMER_IRQ`=1. Write `CTRL`=0x7 → `FLAG` clears and `EN`/`IRQ_EN` stay 1. Write `CTRL`=0x4 on the exact match cycle → `FLAG` stays 1.
- Wrap/override: `COUNT`=0xFFFFFFFE with `EN`=1 → reads 0xFFFFFFFF, then 0x00000000. A `COUNT` write of 0x100 during counting → next read returns 0x100, not 0x101+.
- Reset mid-operation: assert `RST` in the same cycle as a write of 0x77 to `GPIO_OUT` → `GPIO_OUT`=0, `Data_BUS_READ`=0, `TIMER_IRQ`=0, all registers read 0 after release. A RAM word written before the reset still reads its old value.
